// File: rtl/m_herloa_pkg.sv
// Shared widths and FSM state encoding for the approximate-adder error monitor.
package m_herloa_pkg;

    localparam int OPND_W  = 64;
    localparam int SUM_W   = 65;
    localparam int EDSUM_W = 97;
    localparam int CNT_W   = 32;

    // Cycles spent draining S1/S2 after the final accept of a window
    localparam int DRAIN_CYC = 2;

    typedef enum logic [1:0] {
        st_accum  = 2'd0,
        st_drain  = 2'd1,
        st_report = 2'd2
    } state_t;

endpackage

// File: rtl/m_herloa_ed_calc.sv
// Error distance between exact and approximate sums, plus a nonzero flag.
module m_herloa_ed_calc
    import m_herloa_pkg::*;
(
    input  logic [SUM_W-1:0] exact,
    input  logic [SUM_W-1:0] approx,
    output logic [SUM_W-1:0] ed,
    output logic             err
);

    always_comb begin
        if (exact >= approx) begin
            ed = exact - approx;
        end else begin
            ed = approx - exact;
        end
        err = (exact != approx);
    end

endmodule

// File: rtl/m_herloa_errmon_64b.sv
// Windowed error-statistics monitor for a 64-bit approximate adder:
// S1 exact add, S2 error distance, accumulate, then hold a report until taken.
module m_herloa_errmon_64b
    import m_herloa_pkg::*;
#(
    parameter int unsigned WINDOW = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPND_W-1:0]   a,
    input  logic [OPND_W-1:0]   b,
    input  logic [SUM_W-1:0]    approx_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    rpt_samples,
    output logic [CNT_W-1:0]    rpt_errors,
    output logic [EDSUM_W-1:0]  rpt_ed_sum,
    output logic [SUM_W-1:0]    rpt_ed_max
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // st_accum  | accepting samples; last accept of the window -> st_drain
    // st_drain  | in_ready low while the final sample flows through S1/S2
    // st_report | out_valid high, rpt_* frozen until out_ready

    localparam logic [CNT_W-1:0] WIN_LOAD   = CNT_W'(WINDOW - 1);
    localparam logic [1:0]       DRAIN_LOAD = 2'(DRAIN_CYC - 1);

    state_t state, state_nxt;

    logic               rdy_en;
    logic               accept;
    logic               report_taken;
    logic [CNT_W-1:0]   win_cnt;
    logic               win_tc;
    logic [1:0]         drain_cnt;

    logic               s1_vld;
    logic [SUM_W-1:0]   s1_exact;
    logic [SUM_W-1:0]   s1_approx;

    logic [SUM_W-1:0]   ed_comb;
    logic               err_comb;
    logic               s2_vld;
    logic [SUM_W-1:0]   s2_ed;
    logic               s2_err;

    logic [CNT_W-1:0]   acc_samples;
    logic [CNT_W-1:0]   acc_errors;
    logic [EDSUM_W-1:0] acc_ed_sum;
    logic [SUM_W-1:0]   acc_ed_max;

    // rdy_en keeps in_ready low during reset even though the FSM sits in st_accum
    assign in_ready     = rdy_en && (state == st_accum);
    assign out_valid    = (state == st_report);
    assign accept       = in_valid && in_ready;
    assign report_taken = out_valid && out_ready;
    assign win_tc       = (win_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_accum;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            st_accum: begin
                if (accept && win_tc) begin
                    state_nxt = st_drain;
                end
            end
            st_drain: begin
                if (drain_cnt == '0) begin
                    state_nxt = st_report;
                end
            end
            st_report: begin
                if (out_ready) begin
                    state_nxt = st_accum;
                end
            end
            default: state_nxt = st_accum;
        endcase
        if (clear) begin
            state_nxt = st_accum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= WIN_LOAD;
        end else if (clear || report_taken) begin
            win_cnt <= WIN_LOAD;
        end else if (accept) begin
            win_cnt <= win_tc ? WIN_LOAD : win_cnt - CNT_W'(1);
        end
    end

    // Reloaded whenever outside st_drain so each drain lasts DRAIN_CYC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state != st_drain) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else if (clear) begin
            s1_vld    <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_exact  <= {1'b0, a} + {1'b0, b};
                s1_approx <= approx_sum;
            end
        end
    end

    m_herloa_ed_calc u_ed_calc (
        .exact  (s1_exact),
        .approx (s1_approx),
        .ed     (ed_comb),
        .err    (err_comb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_ed  <= '0;
            s2_err <= 1'b0;
        end else if (clear) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_ed  <= ed_comb;
                s2_err <= err_comb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_samples <= '0;
            acc_errors  <= '0;
            acc_ed_sum  <= '0;
            acc_ed_max  <= '0;
        end else if (clear || report_taken) begin
            acc_samples <= '0;
            acc_errors  <= '0;
            acc_ed_sum  <= '0;
            acc_ed_max  <= '0;
        end else if (s2_vld) begin
            acc_samples <= acc_samples + CNT_W'(1);
            acc_errors  <= acc_errors + CNT_W'(s2_err);
            acc_ed_sum  <= acc_ed_sum + EDSUM_W'(s2_ed);
            if (s2_ed > acc_ed_max) begin
                acc_ed_max <= s2_ed;
            end
        end
    end

    assign rpt_samples = out_valid ? acc_samples : '0;
    assign rpt_errors  = out_valid ? acc_errors  : '0;
    assign rpt_ed_sum  = out_valid ? acc_ed_sum  : '0;
    assign rpt_ed_max  = out_valid ? acc_ed_max  : '0;

endmodule

// File: tb/tb_m_herloa_errmon_64b.sv
// Bench for m_herloa_errmon_64b with WINDOW=4: table windows, corner sequences, random windows.
module tb_m_herloa_errmon_64b;

    localparam int W = 4;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] ap;
    } smp_t;

    typedef struct packed {
        smp_t [3:0]  s;
        logic [31:0] errs;
        logic [96:0] sum;
        logic [64:0] mx;
    } win_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [64:0]  approx_sum;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  rpt_samples;
    logic [31:0]  rpt_errors;
    logic [96:0]  rpt_ed_sum;
    logic [64:0]  rpt_ed_max;

    int n_cmp = 0;
    int n_bad = 0;

    smp_t cur [4];
    win_t tbl [3];

    m_herloa_errmon_64b #(.WINDOW(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .approx_sum  (approx_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rpt_samples (rpt_samples),
        .rpt_errors  (rpt_errors),
        .rpt_ed_sum  (rpt_ed_sum),
        .rpt_ed_max  (rpt_ed_max)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic smp_t mk(input logic [63:0] a_, input logic [63:0] b_, input logic [64:0] ap_);
        smp_t s;
        s.a  = a_;
        s.b  = b_;
        s.ap = ap_;
        return s;
    endfunction

    // Error distance straight from its definition: |(a+b) - approx|
    function automatic logic [64:0] ed_of(input smp_t s);
        logic [64:0] ex;
        ex = {1'b0, s.a} + {1'b0, s.b};
        return (ex >= s.ap) ? ex - s.ap : s.ap - ex;
    endfunction

    task automatic model(output logic [31:0] e, output logic [96:0] sm, output logic [64:0] mx);
        logic [64:0] d;
        e = 0; sm = 0; mx = 0;
        for (int i = 0; i < W; i++) begin
            d = ed_of(cur[i]);
            if (d != 0) e++;
            sm += {32'd0, d};
            if (d > mx) mx = d;
        end
    endtask

    task automatic chk_zero_rpt(input string nm);
        chk({nm, "_samples"}, rpt_samples, 0);
        chk({nm, "_errors"},  rpt_errors,  0);
        chk({nm, "_edsum"},   rpt_ed_sum,  0);
        chk({nm, "_edmax"},   rpt_ed_max,  0);
    endtask

    // Offer cur[0..n-1]; each one advances only on an edge where in_ready was high
    task automatic feed(input int n, input int gap_pct);
        int i = 0;
        int budget = 0;
        logic rdy, go;
        while (i < n && budget < 100) begin
            budget++;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid   = 1'b1;
                a          = cur[i].a;
                b          = cur[i].b;
                approx_sum = cur[i].ap;
            end
            rdy = in_ready;
            go  = in_valid;
            tick;
            if (go && rdy) i++;
        end
        in_valid = 1'b0;
        if (i < n) chk("accept_budget", 128'(i), 128'(n));
    endtask

    // Called one edge after the last accept of a window
    task automatic finish_window(input logic [31:0] e_err, input logic [96:0] e_sum,
                                 input logic [64:0] e_max, input int bp,
                                 input logic junk, input logic clr_rep);
        if (junk) begin
            in_valid   = 1'b1;
            a          = 64'hFFFF;
            b          = 64'h1;
            approx_sum = 65'h0;
        end
        chk("drain1_out_valid", out_valid, 0);
        chk("drain1_in_ready",  in_ready,  0);
        tick;
        chk("drain2_out_valid", out_valid, 0);
        chk("drain2_in_ready",  in_ready,  0);
        tick;
        chk("report_out_valid", out_valid, 1);
        chk("report_in_ready",  in_ready,  0);
        chk("rpt_samples", rpt_samples, 32'd4);
        chk("rpt_errors",  rpt_errors,  e_err);
        chk("rpt_ed_sum",  rpt_ed_sum,  e_sum);
        chk("rpt_ed_max",  rpt_ed_max,  e_max);
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            tick;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_samples",   rpt_samples, 32'd4);
            chk("bp_errors",    rpt_errors,  e_err);
            chk("bp_ed_sum",    rpt_ed_sum,  e_sum);
            chk("bp_ed_max",    rpt_ed_max,  e_max);
        end
        in_valid = 1'b0;
        if (clr_rep) begin
            clear = 1'b1;
            tick;
            clear = 1'b0;
            chk("clr_rep_out_valid", out_valid, 0);
            chk("clr_rep_in_ready",  in_ready,  1);
            chk_zero_rpt("clr_rep");
        end else begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            chk("hs_out_valid", out_valid, 0);
            chk("hs_in_ready",  in_ready,  1);
            chk_zero_rpt("hs");
        end
    endtask

    task automatic load_zero;
        for (int i = 0; i < W; i++) cur[i] = mk(64'd0, 64'd0, 65'd0);
    endtask

    task automatic load_err;
        for (int i = 0; i < W; i++) cur[i] = mk(64'd100, 64'd1, 65'd7);
    endtask

    initial begin
        logic [31:0] e_err;
        logic [96:0] e_sum;
        logic [64:0] e_max;

        tbl[0].s[0] = mk(64'd0, 64'd0, 65'd0);
        tbl[0].s[1] = mk(64'd0, 64'd0, 65'd0);
        tbl[0].s[2] = mk(64'd0, 64'd0, 65'd0);
        tbl[0].s[3] = mk(64'd0, 64'd0, 65'd0);
        tbl[0].errs = 32'd0;
        tbl[0].sum  = 97'd0;
        tbl[0].mx   = 65'd0;

        tbl[1].s[0] = mk(64'd0, 64'd0, 65'd1);
        tbl[1].s[1] = mk(64'd5, 64'd5, 65'd7);
        tbl[1].s[2] = mk(64'd0, 64'd0, 65'h0_FFFF_FFFF);
        tbl[1].s[3] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000);
        tbl[1].errs = 32'd3;
        tbl[1].sum  = 97'h1_0000_0003;
        tbl[1].mx   = 65'hFFFF_FFFF;

        tbl[2].s[0] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'd0);
        tbl[2].s[1] = mk(64'd1, 64'd2, 65'd3);
        tbl[2].s[2] = mk(64'd0, 64'd0, 65'h1_0000_0000_0000_0000);
        tbl[2].s[3] = mk(64'd9, 64'd0, 65'd9);
        tbl[2].errs = 32'd2;
        tbl[2].sum  = 97'h2_FFFF_FFFF_FFFF_FFFE;
        tbl[2].mx   = 65'h1_FFFF_FFFF_FFFF_FFFE;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; approx_sum = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk_zero_rpt("rst");
        #10 rst = 1'b0;
        tick;
        chk("rel_in_ready", in_ready, 1);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < W; i++) cur[i] = tbl[t].s[i];
            feed(W, 0);
            finish_window(tbl[t].errs, tbl[t].sum, tbl[t].mx, (t == 1) ? 5 : 0, t == 2, 1'b0);
        end

        // clear after two accepts abandons the window
        load_err;
        feed(2, 0);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("clr_no_out_valid", out_valid, 0);
            tick;
        end
        load_zero;
        feed(W, 0);
        finish_window(0, 0, 0, 0, 1'b0, 1'b0);

        // clear coincident with an accept discards that sample
        load_err;
        feed(1, 0);
        in_valid = 1'b1; a = 64'd50; b = 64'd50; approx_sum = 65'd1;
        clear = 1'b1;
        tick;
        clear = 1'b0; in_valid = 1'b0;
        load_zero;
        feed(W, 0);
        finish_window(0, 0, 0, 0, 1'b0, 1'b0);

        // clear while a report is pending drops it
        load_err;
        feed(W, 0);
        finish_window(32'd4, 97'd376, 65'd94, 1, 1'b0, 1'b1);
        load_zero;
        feed(W, 0);
        finish_window(0, 0, 0, 0, 1'b0, 1'b0);

        // reset mid-window discards partial statistics
        load_err;
        feed(2, 0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready",  in_ready,  0);
        chk_zero_rpt("mrst");
        @(negedge clk);
        rst = 1'b0;
        tick;
        chk("mrst_rel_in_ready", in_ready, 1);
        load_zero;
        feed(W, 0);
        finish_window(0, 0, 0, 0, 1'b0, 1'b0);

        // reset while in REPORT
        load_err;
        feed(W, 0);
        tick;
        tick;
        chk("prerst_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rrst_out_valid", out_valid, 0);
        chk_zero_rpt("rrst");
        @(negedge clk);
        rst = 1'b0;
        tick;
        chk("rrst_rel_in_ready", in_ready, 1);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < W; i++) begin
                cur[i].a = {$urandom, $urandom};
                cur[i].b = {$urandom, $urandom};
                case ($urandom_range(2))
                    0: cur[i].ap = {1'b0, cur[i].a} + {1'b0, cur[i].b};
                    1: cur[i].ap = {1'b0, cur[i].a} + {1'b0, cur[i].b} + 65'($urandom_range(15)) - 65'd7;
                    default: cur[i].ap = {1'($urandom), $urandom, $urandom};
                endcase
            end
            model(e_err, e_sum, e_max);
            feed(W, 30);
            finish_window(e_err, e_sum, e_max, int'($urandom_range(3)), 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_herloa_errmon_64b.md
M_HERLOA_ERRMON_64B -- requirements
Module: m_herloa_errmon_64b

Interface
REQ-001 SHALL have parameter WINDOW, default 1024, meaning the number of samples per statistics report (legal range 1..2^32-1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port clear, input, 1, synchronous abandon of the current window.
REQ-005 SHALL have port in_valid, input, 1, the sample-present qualifier.
REQ-006 SHALL have port in_ready, output, 1, the sample-accept qualifier.
REQ-007 SHALL have ports a and b, input, 64 each, the adder operands.
REQ-008 SHALL have port approx_sum, input, 65, the approximate adder result under test.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the report handshake.
REQ-010 SHALL have report outputs:
- rpt_samples, output, 32: samples in the window.
- rpt_errors, output, 32: samples with nonzero error.
- rpt_ed_sum, output, 97: sum of error distances.
- rpt_ed_max, output, 65: maximum error distance.

Function
REQ-011 SHALL accept a sample on a rising edge where in_valid and in_ready are both 1; in_valid while in_ready is 0 SHALL be ignored.
REQ-012 SHALL compute exact = a + b as an unsigned 65-bit value in stage S1, registered on the accept edge E0.
REQ-013 SHALL compute ED = |exact - approx_sum| (65-bit unsigned) and err = (ED != 0) in stage S2, registered at E1.
REQ-014 SHALL update the accumulators at E2: samples+1, errors+err, ed_sum+ED, ed_max = max(ed_max, ED).
- Accumulator widths make overflow impossible; no saturation is required.
REQ-015 SHALL implement a state machine with states ACCUM, DRAIN and REPORT.
REQ-016 In ACCUM, in_ready SHALL be 1; the accept edge of the WINDOW-th sample SHALL move the FSM to DRAIN.
REQ-017 In DRAIN, in_ready SHALL be 0 for exactly 2 cycles, then the FSM SHALL enter REPORT.
- out_valid is therefore visible in the cycle after E2 of the final sample.
REQ-018 In REPORT, out_valid SHALL be 1, in_ready SHALL be 0, and rpt_* SHALL hold the final window values stable until handshake.
REQ-019 On out_valid && out_ready, the next edge SHALL:
- zero all accumulators;
- enter ACCUM;
- drive out_valid to 0 and in_ready to 1.
REQ-020 Outside REPORT, rpt_* SHALL read zero.
REQ-021 clear SHALL take priority over every other event, with these effects on the next edge:
- flush S1/S2;
- zero the accumulators and the accept counter;
- enter ACCUM.
A report pending in REPORT SHALL be dropped.
REQ-022 clear coincident with an accept SHALL discard that sample.
REQ-023 With WINDOW=1, every accept SHALL go directly to DRAIN.

Reset
REQ-024 While rst=1, asynchronously:
- in_ready=0, out_valid=0, all rpt_* zero;
- pipeline valids cleared, accumulators zero, FSM in ACCUM.
REQ-025 On the first edge after rst deasserts, in_ready SHALL be 1.
REQ-026 rst asserted mid-window or in REPORT SHALL discard all statistics with no partial report.

Structure
REQ-027 The 65-bit/97-bit width constants and the FSM state enumeration SHALL live in a shared package, m_herloa_pkg.
REQ-028 The ED datapath (subtract, absolute value, nonzero flag) SHALL be one sub-module, m_herloa_ed_calc, which is purely combinational.
REQ-029 The block SHALL contain no adder instance of its own beyond the exact 65-bit add in S1.

Verification (bench uses WINDOW=4)
REQ-030 Reset: rst pulse -> out_valid=0, rpt_*=0 asynchronously; in_ready=1 one edge after release.
REQ-031 Exact window: 4 samples with a=b=0 and approx_sum=0 -> out_valid 2 cycles after the 4th accept; samples=4, errors=0, ed_sum=0, ed_max=0.
REQ-032 Error statistics: input four samples:
- a=0, b=0, approx=1;
- a=5, b=5, approx=7;
- a=0, b=0, approx=0x0_FFFFFFFF;
- a=2^63, b=2^63, approx=2^64.
Required report: samples=4, errors=3, ed_sum=0x100000003, ed_max=0xFFFFFFFF.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in REPORT -> rpt_* stable and in_ready=0 throughout; handshake -> next cycle in_ready=1 and accumulators zero.
REQ-034 Clear: assert clear after 2 accepts -> no out_valid; the next 4 accepts produce a report with samples=4. clear during REPORT -> out_valid=0 next cycle.
REQ-035 Ignored input: in_valid=1 during DRAIN/REPORT with nonzero-error data -> that data does not affect any count.
